// File: rtl/trip_controller_pkg.sv
// Shared definitions for the trip controller: state encoding, parameter defaults
// and the display-select cycling helper.
package trip_controller_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED   = 2'd0,
        ST_RUNNING   = 2'd1,
        ST_AUTOPAUSE = 2'd2,
        ST_SET_CIRC  = 2'd3
    } state_t;

    localparam int DEF_CIRC_DEFAULT = 220;
    localparam int DEF_CIRC_MIN     = 150;
    localparam int DEF_CIRC_MAX     = 250;
    localparam int DEF_IDLE_TIMEOUT = 4000;

    // Display code shown while the circumference is being edited
    localparam logic [1:0] DISP_CIRC = 2'd3;

    // User-selectable display cycles 0 -> 1 -> 2 -> 0
    function automatic logic [1:0] next_disp(input logic [1:0] d);
        return (d >= 2'd2) ? 2'd0 : d + 2'd1;
    endfunction

endpackage

// File: rtl/trip_controller_idle_timer.sv
// Counts cycles since the last wheel pulse; flags expiry one count before the
// timeout so the controller can leave RUNNING on the IDLE_TIMEOUT-th edge.
module idle_timer #(
    parameter int LIMIT = 4000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Saturates at LAST so the counter can never wrap back to zero
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (count_en && (count_reg != LAST)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/trip_controller.sv
// Bicycle trip computer control FSM: start/stop, auto-pause on wheel idle,
// display selection and circumference editing. All outputs are registered.
module trip_controller
    import trip_controller_pkg::*;
#(
    parameter int CIRC_DEFAULT = DEF_CIRC_DEFAULT,
    parameter int CIRC_MIN     = DEF_CIRC_MIN,
    parameter int CIRC_MAX     = DEF_CIRC_MAX,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_clear,
    input  logic       reed,
    output logic       enable,
    output logic [7:0] circ,
    output logic       trip_clear,
    output logic [1:0] disp_sel,
    output logic       running,
    output logic       paused
);

    localparam logic [7:0] CIRC_DEF8 = 8'(CIRC_DEFAULT);
    localparam logic [7:0] CIRC_MIN8 = 8'(CIRC_MIN);
    localparam logic [7:0] CIRC_MAX8 = 8'(CIRC_MAX);

    state_t     state_reg, state_next;
    logic [1:0] disp_mode_reg, disp_mode_next;
    logic [7:0] circ_reg, circ_next;
    logic       trip_clear_reg, trip_clear_next;
    logic       enable_reg, enable_next;
    logic       running_reg, running_next;
    logic       paused_reg, paused_next;
    logic [1:0] disp_sel_reg, disp_sel_next;

    logic act_start, act_set, act_clear, act_mode;
    logic idle_expired;

    // The idle count only advances while RUNNING; anywhere else it is held at zero
    idle_timer #(
        .LIMIT (IDLE_TIMEOUT)
    ) u_idle_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (reed || (state_reg != ST_RUNNING)),
        .count_en (state_reg == ST_RUNNING),
        .expired  (idle_expired)
    );

    // One button per cycle: start > set > clear > mode
    assign act_start = btn_start;
    assign act_set   = btn_set && !btn_start;
    assign act_clear = btn_clear && !btn_set && !btn_start;
    assign act_mode  = btn_mode && !btn_clear && !btn_set && !btn_start;

    always_comb begin
        state_next      = state_reg;
        disp_mode_next  = disp_mode_reg;
        circ_next       = circ_reg;
        trip_clear_next = 1'b0;

        case (state_reg)
            ST_STOPPED: begin
                if (act_start) begin
                    state_next = ST_RUNNING;
                end else if (act_set) begin
                    state_next = ST_SET_CIRC;
                end else if (act_clear) begin
                    trip_clear_next = 1'b1;
                end else if (act_mode) begin
                    disp_mode_next = next_disp(disp_mode_reg);
                end
            end
            ST_RUNNING: begin
                if (act_start) begin
                    state_next = ST_STOPPED;
                end else begin
                    if (act_mode) begin
                        disp_mode_next = next_disp(disp_mode_reg);
                    end
                    if (!reed && idle_expired) begin
                        state_next = ST_AUTOPAUSE;
                    end
                end
            end
            ST_AUTOPAUSE: begin
                if (act_start) begin
                    state_next = ST_STOPPED;
                end else begin
                    if (act_mode) begin
                        disp_mode_next = next_disp(disp_mode_reg);
                    end
                    if (reed) begin
                        state_next = ST_RUNNING;
                    end
                end
            end
            ST_SET_CIRC: begin
                if (act_set) begin
                    state_next = ST_STOPPED;
                end else if (act_mode) begin
                    circ_next = ((circ_reg >= CIRC_MAX8) || (circ_reg < CIRC_MIN8))
                                ? CIRC_MIN8 : circ_reg + 8'd1;
                end
            end
            default: begin
                state_next = ST_STOPPED;
            end
        endcase

        // Outputs decode the next state so the registered copies track state_reg
        enable_next   = (state_next == ST_RUNNING);
        running_next  = (state_next == ST_RUNNING) || (state_next == ST_AUTOPAUSE);
        paused_next   = (state_next == ST_AUTOPAUSE);
        disp_sel_next = (state_next == ST_SET_CIRC) ? DISP_CIRC : disp_mode_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_STOPPED;
            disp_mode_reg  <= 2'd0;
            circ_reg       <= CIRC_DEF8;
            trip_clear_reg <= 1'b0;
            enable_reg     <= 1'b0;
            running_reg    <= 1'b0;
            paused_reg     <= 1'b0;
            disp_sel_reg   <= 2'd0;
        end else begin
            state_reg      <= state_next;
            disp_mode_reg  <= disp_mode_next;
            circ_reg       <= circ_next;
            trip_clear_reg <= trip_clear_next;
            enable_reg     <= enable_next;
            running_reg    <= running_next;
            paused_reg     <= paused_next;
            disp_sel_reg   <= disp_sel_next;
        end
    end

    assign enable     = enable_reg;
    assign circ       = circ_reg;
    assign trip_clear = trip_clear_reg;
    assign disp_sel   = disp_sel_reg;
    assign running    = running_reg;
    assign paused     = paused_reg;

endmodule

// File: tb/tb_trip_controller.sv
// Directed bench for trip_controller: reset, run/auto-pause timing, display
// cycling, button priority, circumference editing and reset during edit.
module tb_trip_controller;
    import trip_controller_pkg::*;

    localparam int L = DEF_IDLE_TIMEOUT;

    logic       clock;
    logic       reset;
    logic       btn_start, btn_mode, btn_set, btn_clear, reed;
    logic       enable;
    logic [7:0] circ;
    logic       trip_clear;
    logic [1:0] disp_sel;
    logic       running;
    logic       paused;

    int checks = 0;
    int errors = 0;

    trip_controller #(
        .CIRC_DEFAULT (DEF_CIRC_DEFAULT),
        .CIRC_MIN     (DEF_CIRC_MIN),
        .CIRC_MAX     (DEF_CIRC_MAX),
        .IDLE_TIMEOUT (DEF_IDLE_TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_start  (btn_start),
        .btn_mode   (btn_mode),
        .btn_set    (btn_set),
        .btn_clear  (btn_clear),
        .reed       (reed),
        .enable     (enable),
        .circ       (circ),
        .trip_clear (trip_clear),
        .disp_sel   (disp_sel),
        .running    (running),
        .paused     (paused)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // b = {start, set, clear, mode, reed}; held for exactly one edge
    task automatic press(input logic [4:0] b);
        {btn_start, btn_set, btn_clear, btn_mode, reed} = b;
        tick();
        {btn_start, btn_set, btn_clear, btn_mode, reed} = 5'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-18s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    localparam logic [4:0] B_START = 5'b10000;
    localparam logic [4:0] B_SET   = 5'b01000;
    localparam logic [4:0] B_CLEAR = 5'b00100;
    localparam logic [4:0] B_MODE  = 5'b00010;
    localparam logic [4:0] B_REED  = 5'b00001;

    initial begin
        {btn_start, btn_set, btn_clear, btn_mode, reed} = 5'b0;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_circ", circ, 220);
        check("rst_disp", disp_sel, 0);
        check("rst_enable", enable, 0);
        check("rst_running", running, 0);
        check("rst_paused", paused, 0);
        check("rst_trip_clear", trip_clear, 0);
        reset = 1'b0;
        repeat (6) tick();
        check("idle_enable", enable, 0);

        // Start, keep the wheel turning, then let it stop
        press(B_START);
        check("start_enable", enable, 1);
        check("start_running", running, 1);
        for (int i = 0; i < 3; i++) begin
            repeat (99) tick();
            press(B_REED);
            check("reed_enable", enable, 1);
            check("reed_paused", paused, 0);
        end
        repeat (L - 1) tick();
        check("pre_timeout_paused", paused, 0);
        check("pre_timeout_enable", enable, 1);
        tick();
        check("timeout_paused", paused, 1);
        check("timeout_enable", enable, 0);
        check("timeout_running", running, 1);
        repeat (5) tick();
        check("ap_hold_paused", paused, 1);
        press(B_REED);
        check("resume_enable", enable, 1);
        check("resume_paused", paused, 0);

        // Display cycling while running
        press(B_MODE);
        check("run_mode1_disp", disp_sel, 1);
        check("run_mode1_enable", enable, 1);
        press(B_MODE);
        check("run_mode2_disp", disp_sel, 2);
        check("run_mode2_enable", enable, 1);
        press(B_MODE);
        check("run_mode3_disp", disp_sel, 0);
        check("run_mode3_enable", enable, 1);

        press(B_START);
        check("stop_enable", enable, 0);
        check("stop_running", running, 0);

        // Trip clear behaviour and start-over-clear priority
        press(B_CLEAR);
        check("clr_pulse", trip_clear, 1);
        tick();
        check("clr_drop", trip_clear, 0);
        press(B_CLEAR);
        check("clr_b2b_first", trip_clear, 1);
        press(B_CLEAR);
        check("clr_b2b_second", trip_clear, 1);
        tick();
        check("clr_b2b_drop", trip_clear, 0);
        press(B_START | B_CLEAR);
        check("start_clr_running", running, 1);
        check("start_clr_noclear", trip_clear, 0);
        press(B_CLEAR);
        check("run_clr_noclear", trip_clear, 0);
        check("run_clr_running", running, 1);
        press(B_START);
        check("stop2_running", running, 0);

        // Circumference edit with wrap, display restore on exit
        press(B_MODE);
        check("stop_mode_disp", disp_sel, 1);
        press(B_SET);
        check("set_disp", disp_sel, 3);
        check("set_circ", circ, 220);
        for (int i = 1; i <= 31; i++) begin
            press(B_MODE);
            check("edit_circ", circ, (220 + i <= 250) ? 220 + i : 150);
        end
        press(B_SET);
        check("exit_disp", disp_sel, 1);
        check("exit_running", running, 0);
        check("exit_circ", circ, 150);
        press(B_CLEAR);
        check("exit_stopped_clr", trip_clear, 1);

        // set beats mode; start ignored in edit
        press(B_SET | B_MODE);
        check("prio_set_disp", disp_sel, 3);
        check("prio_set_circ", circ, 150);
        press(B_START);
        check("edit_start_ign", running, 0);
        check("edit_start_disp", disp_sel, 3);
        for (int i = 0; i < 90; i++) press(B_MODE);
        check("edit_to_240", circ, 240);

        // Reset discards the edit
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_circ", circ, 220);
        check("mid_rst_disp", disp_sel, 0);
        check("mid_rst_running", running, 0);
        press(B_CLEAR);
        check("mid_rst_stopped", trip_clear, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
